// File: rtl/binary_morph_3x3.sv
// Binary 3x3 dilation/erosion on a thresholded video stream (pixel = din_data[7]).
// Data and sync leave exactly LAT=3 clocks after entry; two 1-bit line buffers supply the rows above.
module binary_morph_3x3 #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int LAT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       din_de,
  input  logic       din_hsync,
  input  logic       din_vsync,
  input  logic [7:0] din_data,
  output logic       dout_de,
  output logic       dout_hsync,
  output logic       dout_vsync,
  output logic [7:0] dout_data,
  output logic       overrun
);

  localparam int CW = $clog2(H_DISP + 1);
  localparam int RW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;

  localparam logic [CW-1:0] COL_SAT  = '1;
  localparam logic [CW-1:0] H_LIM    = CW'(H_DISP);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_DISP - 1);

  // ---------------------------------------------------------------------------
  // Sync delay lines; tap [0] doubles as the previous-cycle value for edge detect
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] de_dly_q, hs_dly_q, vs_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_dly_q <= '0;
      hs_dly_q <= '0;
      vs_dly_q <= '0;
    end else begin
      de_dly_q <= {de_dly_q[LAT-2:0], din_de};
      hs_dly_q <= {hs_dly_q[LAT-2:0], din_hsync};
      vs_dly_q <= {vs_dly_q[LAT-2:0], din_vsync};
    end
  end

  // ---------------------------------------------------------------------------
  // Frame / line tracking
  // ---------------------------------------------------------------------------
  logic          frame_start;
  logic          de_fall;
  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          mode_lat_q, mode_lat_d, mode_eff;
  logic          frame_valid_q, frame_valid_d, frame_valid_eff;
  logic          overrun_q, overrun_d;
  logic          in_range;
  logic          pix;

  assign frame_start     = din_vsync & ~vs_dly_q[0];
  assign de_fall         = ~din_de & de_dly_q[0];
  // A frame start overrides the counters in the same cycle it is seen.
  assign col_eff         = frame_start ? '0 : col_q;
  assign row_eff         = frame_start ? '0 : row_q;
  assign mode_eff        = frame_start ? mode : mode_lat_q;
  assign frame_valid_eff = frame_start | frame_valid_q;
  assign in_range        = (col_eff < H_LIM);
  assign pix             = din_data[7];

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    mode_lat_d    = mode_lat_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    if (frame_start) begin
      mode_lat_d    = mode;
      frame_valid_d = 1'b1;
      overrun_d     = 1'b0;
      row_d         = '0;
      col_d         = '0;
    end
    if (din_de) begin
      if (col_eff != COL_SAT) begin
        col_d = col_eff + 1'b1;
      end
      if (!in_range) begin
        overrun_d = 1'b1;
      end
    end else if (de_fall && !frame_start) begin
      col_d = '0;
      if (row_q != ROW_LAST) begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      mode_lat_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      mode_lat_q    <= mode_lat_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (read-before-write)
  // ---------------------------------------------------------------------------
  logic          lb1_mem [H_DISP];
  logic          lb2_mem [H_DISP];
  logic [AW-1:0] lb_addr;
  logic          lb_we;
  logic          rd1_q, rd2_q;

  assign lb_addr = in_range ? col_eff[AW-1:0] : '0;
  assign lb_we   = din_de & in_range;

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1_mem[lb_addr] <= pix;
      lb2_mem[lb_addr] <= lb1_mem[lb_addr];
    end
    rd1_q <= lb1_mem[lb_addr];
    rd2_q <= lb2_mem[lb_addr];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: position flags travelling alongside the RAM read
  // ---------------------------------------------------------------------------
  logic pix_s1_q, row_ge1_s1_q, row_ge2_s1_q, col0_s1_q, ok_s1_q, mode_s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1_q     <= 1'b0;
      row_ge1_s1_q <= 1'b0;
      row_ge2_s1_q <= 1'b0;
      col0_s1_q    <= 1'b0;
      ok_s1_q      <= 1'b0;
      mode_s1_q    <= 1'b0;
    end else begin
      pix_s1_q     <= pix;
      row_ge1_s1_q <= (row_eff >= RW'(1));
      row_ge2_s1_q <= (row_eff >= RW'(2));
      col0_s1_q    <= (col_eff == '0);
      ok_s1_q      <= din_de & in_range & frame_valid_eff;
      mode_s1_q    <= mode_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 3x3 window, columns c (win0), c-1 (win1), c-2 (win2);
  // bit 0 = row r, bit 1 = row r-1, bit 2 = row r-2
  // ---------------------------------------------------------------------------
  logic [2:0] win0_q, win1_q, win2_q;
  logic [2:0] win0_d, win1_d, win2_d;
  logic [2:0] new_col;
  logic [2:0] pad_col;
  logic       ok_s2_q, mode_s2_q;

  assign pad_col = {3{mode_s1_q}};
  assign new_col = {row_ge2_s1_q ? rd2_q : mode_s1_q,
                    row_ge1_s1_q ? rd1_q : mode_s1_q,
                    pix_s1_q};

  always_comb begin
    win0_d = win0_q;
    win1_d = win1_q;
    win2_d = win2_q;
    if (de_dly_q[0]) begin
      win0_d = new_col;
      win1_d = col0_s1_q ? pad_col : win0_q;
      win2_d = col0_s1_q ? pad_col : win1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win0_q    <= '0;
      win1_q    <= '0;
      win2_q    <= '0;
      ok_s2_q   <= 1'b0;
      mode_s2_q <= 1'b0;
    end else begin
      win0_q    <= win0_d;
      win1_q    <= win1_d;
      win2_q    <= win2_d;
      ok_s2_q   <= ok_s1_q;
      mode_s2_q <= mode_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: reduce and register
  // ---------------------------------------------------------------------------
  logic       morph_bit;
  logic [7:0] data_q, data_d;

  assign morph_bit = mode_s2_q ? (&{win2_q, win1_q, win0_q})
                               : (|{win2_q, win1_q, win0_q});

  always_comb begin
    data_d = 8'h00;
    if (de_dly_q[1] && ok_s2_q && morph_bit) begin
      data_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout_de    = de_dly_q[LAT-1];
  assign dout_hsync = hs_dly_q[LAT-1];
  assign dout_vsync = vs_dly_q[LAT-1];
  assign dout_data  = data_q;

  logic unused_data;
  assign unused_data = ^din_data[6:0];

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Bench for binary_morph_3x3: reset table plus frame-level scoreboard against a 2-D reference model.
module tb_binary_morph_3x3;

  localparam int H   = 40;
  localparam int V   = 32;
  localparam int HB  = 8;
  localparam int VB  = 3;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       din_de, din_hsync, din_vsync;
  logic [7:0] din_data;
  logic       dout_de, dout_hsync, dout_vsync;
  logic [7:0] dout_data;
  logic       overrun;

  binary_morph_3x3 #(.H_DISP(H), .V_DISP(V), .LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .din_de     (din_de),
    .din_hsync  (din_hsync),
    .din_vsync  (din_vsync),
    .din_data   (din_data),
    .dout_de    (dout_de),
    .dout_hsync (dout_hsync),
    .dout_vsync (dout_vsync),
    .dout_data  (dout_data),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       de, hs, vs;
    logic [7:0] data;
    string      tag;
  } exp_t;

  typedef struct {
    logic       rst, de, hs, vs, md;
    logic [7:0] data;
    logic       e_de, e_hs, e_vs, e_ovr;
    logic [7:0] e_data;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   img [V][H];
  bit   fr_mode;
  bit   fr_valid;
  vec_t tbl [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic de, input logic hs, input logic vs,
                               input logic ede, input logic ehs, input logic evs);
    vec_t v;
    v.rst = r; v.de = de; v.hs = hs; v.vs = vs;
    v.md = 1'($urandom);
    v.data = r ? 8'($urandom) : 8'hFF;
    v.e_de = ede; v.e_hs = ehs; v.e_vs = evs;
    v.e_ovr = 1'b0; v.e_data = 8'h00;
    return v;
  endfunction

  // Reference: window rows r-2..r, cols c-2..c; taps off the image take the pad value.
  function automatic logic morph(input int r, input int c);
    logic acc, v;
    acc = fr_mode;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if (r - dr < 0 || c - dc < 0) v = fr_mode;
        else                          v = img[r-dr][c-dc];
        acc = fr_mode ? (acc & v) : (acc | v);
      end
    end
    return acc;
  endfunction

  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [7:0] data,
                     input logic [7:0] edata, input string tag);
    exp_t e, x;
    din_de = de; din_hsync = hs; din_vsync = vs; din_data = data;
    e.de = de; e.hs = hs; e.vs = vs; e.data = edata; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() > 2) begin
      x = sb_q.pop_front();
      check(x.tag, 16'({dout_de, dout_hsync, dout_vsync, dout_data}),
                   16'({x.de, x.hs, x.vs, x.data}));
    end
  endtask

  task automatic rst_cyc(input logic de, input logic hs, input logic vs, input logic [7:0] data);
    exp_t z;
    rst = 1'b1;
    din_de = de; din_hsync = hs; din_vsync = vs; din_data = data;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_outputs", 16'({dout_de, dout_hsync, dout_vsync, dout_data, overrun}), 16'h0);
    fr_valid = 1'b0;
    sb_q.delete();
    z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.data = 8'h00; z.tag = "post_rst";
    sb_q.push_back(z);
    sb_q.push_back(z);
  endtask

  task automatic run_frame(input string nm, input bit md, input bit bg, input int sr, input int sc,
                           input int tog_row, input int ovr_row, input int rst_row, input bit vs_on_de);
    bit first;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = bg;
    img[sr][sc] = ~bg;
    mode  = md;
    first = 1'b1;
    if (!vs_on_de) begin
      fr_mode = md; fr_valid = 1'b1;
      for (int l = 0; l < VB; l++) begin
        for (int c = 0; c < H + HB; c++) begin
          cyc(1'b0, (c >= H + 2 && c < H + 5), 1'b1, 8'h00, 8'h00, $sformatf("%s vblank", nm));
          if (first) begin
            check($sformatf("%s ovr_clear", nm), 16'(overrun), 16'h0);
            first = 1'b0;
          end
        end
      end
    end else begin
      fr_mode = md; fr_valid = 1'b1;
    end
    for (int r = 0; r < V; r++) begin
      int n = (r == ovr_row) ? H + 10 : H;
      for (int c = 0; c < n; c++) begin
        logic [7:0] px;
        logic       vs;
        px = (c >= H || img[r][c]) ? 8'hFF : 8'h00;
        vs = vs_on_de && (r == 0);
        if (r == tog_row && c == 0) mode = ~mode;
        if (r == rst_row && c == 5) begin
          rst_cyc(1'b1, 1'b0, vs, px);
        end else begin
          cyc(1'b1, 1'b0, vs, px, (fr_valid && c < H && morph(r, c)) ? 8'hFF : 8'h00,
              $sformatf("%s px r%0d c%0d", nm, r, c));
        end
        if (first) begin
          check($sformatf("%s ovr_clear", nm), 16'(overrun), 16'h0);
          first = 1'b0;
        end
        if (r == ovr_row && c == H - 1) check($sformatf("%s ovr_pre", nm), 16'(overrun), 16'h0);
        if (r == ovr_row && c == H)     check($sformatf("%s ovr_set", nm), 16'(overrun), 16'h1);
      end
      for (int c = 0; c < HB; c++)
        cyc(1'b0, (c >= 2 && c < 5), 1'b0, 8'h00, 8'h00, $sformatf("%s hblank r%0d", nm, r));
    end
    check($sformatf("%s ovr_end", nm), 16'(overrun),
          16'((ovr_row >= 0 && rst_row < 0) ? 1 : 0));
  endtask

  initial begin
    rst = 1'b0; mode = 1'b0;
    din_de = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0; din_data = 8'h00;
    fr_mode = 1'b0; fr_valid = 1'b0;

    // Reset with random inputs, then three dead output cycles, then the delayed syncs.
    tbl[0] = mkv(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
    tbl[1] = mkv(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
    tbl[2] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[6] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[7] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; mode = tbl[i].md;
      din_de = tbl[i].de; din_hsync = tbl[i].hs; din_vsync = tbl[i].vs; din_data = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("reset_tbl[%0d]", i),
            16'({dout_de, dout_hsync, dout_vsync, dout_data, overrun}),
            16'({tbl[i].e_de, tbl[i].e_hs, tbl[i].e_vs, tbl[i].e_data, tbl[i].e_ovr}));
    end
    rst = 1'b0;

    rst_cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "idle");

    //        name        md   bg   sr     sc    tog  ovr  rst  vs_on_de
    run_frame("dil_pt",   1'b0, 1'b0, 10,    10,   -1,  -1,  -1,  1'b0);
    run_frame("ero_hole", 1'b1, 1'b1, 20,    30,   -1,  -1,  -1,  1'b0);
    run_frame("mode_tog", 1'b0, 1'b0, 10,    10,   16,  -1,  -1,  1'b0);
    run_frame("ero_next", 1'b1, 1'b0, 10,    10,   -1,  -1,  -1,  1'b0);
    run_frame("overrun",  1'b0, 1'b0, 10,    10,   -1,   5,  -1,  1'b0);
    run_frame("mid_rst",  1'b1, 1'b1, 20,    30,   -1,  -1,  20,  1'b0);
    run_frame("vs_de",    1'b0, 1'b0,  0,     0,   -1,  -1,  -1,  1'b1);
    run_frame("ero_edge", 1'b1, 1'b1, V-1,  H-1,   -1,  -1,  -1,  1'b0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_morph_3x3.md
Name: binary_morph_3x3

Overview:
- Post-processing stage that consumes the binary edge stream from the 5x5 Sobel edge detector.
- Applies a 3x3 binary dilation or erosion to close gaps in edges or remove isolated edge pixels.
- Owns two 1-bit line buffers and pixel/row counters.
- Re-emits the de/hsync/vsync video timing with a fixed delay so it drops straight into the existing filter chain.

Parameters:
- H_DISP, 640: active pixels per line; sets line-buffer depth and the column-counter limit.
- V_DISP, 480: active lines per frame; sets the row-counter limit.
- LAT, 3: fixed pipeline latency in clocks. Not to be overridden.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = dilation (OR of window), 1 = erosion (AND of window). Sampled at frame start only.
- din_de  in  1  input data enable.
- din_hsync  in  1  input line sync.
- din_vsync  in  1  input frame sync.
- din_data  in  8  input pixel; pixel bit = din_data[7].
- dout_de  out  1  din_de delayed LAT clocks.
- dout_hsync  out  1  din_hsync delayed LAT clocks.
- dout_vsync  out  1  din_vsync delayed LAT clocks.
- dout_data  out  8  8'hFF or 8'h00.
- overrun  out  1  sticky: a line exceeded H_DISP pixels.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - all outputs 0; delay lines 0; col/row counters 0; mode_lat=0; frame_valid=0; overrun=0.
  - Line-buffer RAM is not cleared.
- Frame start = rising edge of din_vsync (registered compare).
  - Loads mode_lat <= mode, row <= 0, col <= 0, frame_valid <= 1, overrun <= 0.
  - mode changes at any other time are ignored.
- Column counter:
  - increments on each din_de=1 cycle.
  - cleared on the din_de falling edge (end of line); row increments at the same point.
  - row saturates at V_DISP-1.
- Line buffers (H_DISP x 1 bit each):
  - read at address col with 1-clock synchronous read.
  - on din_de, lb1[col] <= pixel bit and lb2[col] <= old lb1[col].
- Window: 3x3 shift register of taps covering rows r-2..r and cols c-2..c, where (r,c) is the current input position.
  - Shifts only on delayed de.
  - Window reset to the padding value at the start of each line.
- Padding, for taps outside the image (r-k<0 or c-k<0): 0 in dilation, 1 in erosion. Selection is by counter value, so stale RAM content never reaches the output.
- Result:
  - dilation: dout bit = OR of 9 taps; erosion: dout bit = AND of 9 taps.
  - dout_data = {8{bit}}, registered.
  - The output at input position (r,c) is the morphology result centred on (r-1,c-1). This fixed (+1,+1) spatial offset is intended.
- Latency: dout_* is exactly LAT=3 clocks after the corresponding din_* (RAM read, window register, result register). This holds for all cycles, including blanking.
- When dout_de=0, dout_data=8'h00.
- Overrun: a pixel with col >= H_DISP is not written to the RAM, its dout_data is 8'h00, and overrun is set. overrun clears only at the next frame start or on rst.
- Reset mid-frame: frame_valid=0 until the next vsync rising edge.
  - Sync signals continue to propagate with LAT delay.
  - dout_data = 8'h00 for all pixels.
- Simultaneous vsync rise and din_de=1: frame start takes priority, so that pixel is counted as col 0, row 0 of the new frame.
- Counters are sized to $clog2(H_DISP+1) and $clog2(V_DISP).

Test Plan:
- Reset: hold rst for 2 clocks with random inputs -> every output 0 from the first clock edge with rst=1; dout_de stays 0 for 3 clocks after release.
- Dilation, single point: 640x480 all-black frame, din_data=8'hFF only at (10,10), mode=0 -> dout_data=8'hFF exactly at input-aligned positions rows 10..12, cols 10..12 (9 pixels), each 3 clocks after its din_de; all other pixels 8'h00.
- Erosion, hole: all-white frame, black pixel at (20,30), mode=1 -> 8'h00 at rows 20..22, cols 30..32; 8'hFF everywhere else, including row 0/col 0 (pad=1).
- Mode latch: mode=0 at frame start, toggled to 1 at row 100, same single-point frame -> whole frame dilated; erosion takes effect from the next frame.
- Overrun: one line driven with 650 de cycles -> pixels 640..649 output 8'h00, overrun=1 from pixel 640 until the next vsync rise; following lines are unaffected.
- Mid-frame reset: rst pulsed 1 clock at row 200 -> dout_data=8'h00 for the rest of the frame while sync keeps a 3-clock delay; the next frame matches the golden model bit-exactly.
